func_unit: RTL and testbench
============================

Name: func_unit

Overview:
- Per-thread execution lane of the mini-GPU core.
- Holds a private 32x32-bit register file and executes one instruction per clock: integer add/sub/mul/div, single-precision float add/sub, bulk register load, or a done marker.
- The warp scheduler instantiates one func_unit per thread lane and gates each lane with is_active.

Parameters:
- None. Data width 32, register count 32 and opcode width 3 are fixed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- type_instruction  in  3  opcode (encoding below)
- regnum_1  in  5  source register A index
- regnum_2  in  5  source register B index
- dest_reg  in  5  destination register index
- shammt  in  6  reserved; ignored by this block; must not affect any output
- init_reg_data  in  32x32 (unpacked [0:31] of 32-bit)  bulk-load image for the register file
- is_active  in  1  lane enable; 0 freezes all state
- final_result  out  32  registered result of the last executed arithmetic op
- thread_complete  out  1  registered; high while a done opcode is executing

Behaviour:
- Reset (rst=1 at a clock edge): all 32 registers, final_result and thread_complete go to 0. rst has priority over every other input, including mid-operation.
- is_active=0: no register write; final_result and thread_complete hold their values.
- Opcode encoding (operands A=R[regnum_1], B=R[regnum_2]):
  - 000: A+B, two's complement, wraps mod 2^32.
  - 001: A-B, two's complement, wraps mod 2^32.
  - 010: low 32 bits of A*B.
  - 011: signed A/B, truncating toward zero. If B=0, result is 0xFFFFFFFF. 0x80000000/0xFFFFFFFF gives 0x80000000.
  - 100: IEEE-754 single-precision A+B.
  - 101: IEEE-754 single-precision A-B.
  - 110: R[i] <= init_reg_data[i] for all i in one cycle; final_result holds.
  - 111: done; no register write; final_result holds.
- Ops 000-101: at the edge, R[dest_reg] <= result and final_result <= result.
  - Single-cycle: combinational datapath, registered outputs, latency 1 clock.
  - R0 is an ordinary writable register, not hardwired to zero.
- Read-after-write: operands are read from the current register state. A write at edge N is visible to the instruction sampled at edge N+1. No internal bypass is needed.
- dest_reg equal to a source register: sources are read before the write (old value used).
- thread_complete <= (type_instruction==111) at each active edge, so it is 0 after any other opcode.
- Floating-point rules:
  - Round to nearest even.
  - Subnormal inputs and outputs are fully supported (no flush-to-zero).
  - Exact zero result is +0, except (-0)+(-0) = -0.
  - Any NaN input, or inf-inf, gives canonical NaN 0x7FC00000.
  - Overflow gives ±inf (0x7F800000 / 0xFF800000).

Optional Feature:
- Macro: FUNC_UNIT_FPU_EN.
- Defined: opcodes 100/101 behave as specified above.
- Undefined: the FP adder is not synthesized. Opcodes 100/101 act as a no-op: no register write, final_result holds, thread_complete <= 0.

Test Plan:
- Reset: rst=1 with type_instruction=111 for one edge, then deassert -> final_result=0, thread_complete=0. Idle 111 cycles with is_active=1 -> thread_complete=1.
- Load then integer ops: opcode 110 with init_reg_data[i]=i, then:
  - add r2,r4->r5 -> final_result=6, R5=6
  - sub r7,r6->r8 -> 1
  - mul r10,r11->r12 -> 110
  - div r14,r15->r16 -> 0
  - each result appears one edge after sampling.
- FP with subnormals (after the same load): fadd r18,r19->r20 -> 0x00000025; fsub r21,r22->r23 -> 0x80000001. Also fadd 0x3F800000+0x40000000 -> 0x40400000 (1.0+2.0=3.0).
- Edge cases:
  - div by zero -> 0xFFFFFFFF
  - 0x80000000 / -1 -> 0x80000000
  - add 0x7FFFFFFF+1 -> 0x80000000
  - fadd 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000
  - fadd NaN+1.0 -> 0x7FC00000
- is_active=0 while issuing add r2,r4->r5 after R5 was cleared -> R5 and final_result unchanged. Reasserting is_active resumes normally.
- Back-to-back dependency: add r1,r1->r1 three consecutive cycles starting from R1=1 -> final_result 2, 4, 8. Toggling shammt has no effect on any result.

Source files
------------

// File: rtl/func_unit.sv
// Per-thread execution lane: private 32x32 register file plus a single-cycle integer/FP datapath.
// Optional macro FUNC_UNIT_FPU_EN enables the IEEE-754 single-precision adder for opcodes 100/101.
module func_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  type_instruction,
    input  logic [4:0]  regnum_1,
    input  logic [4:0]  regnum_2,
    input  logic [4:0]  dest_reg,
    input  logic [5:0]  shammt,
    input  logic [31:0] init_reg_data [0:31],
    input  logic        is_active,
    output logic [31:0] final_result,
    output logic        thread_complete
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_FADD = 3'b100,
        OP_FSUB = 3'b101,
        OP_LOAD = 3'b110,
        OP_DONE = 3'b111
    } opcode_e;

    logic [31:0] regs [0:31];
    logic [31:0] op_a, op_b, result;
    logic        wr_en;
    opcode_e     op;

    // shammt is a reserved field; reducing it into an unused net keeps it out of the datapath.
    logic unused_shammt;
    assign unused_shammt = ^shammt;

    assign op   = opcode_e'(type_instruction);
    assign op_a = regs[regnum_1];
    assign op_b = regs[regnum_2];

`ifdef FUNC_UNIT_FPU_EN
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    // Round-to-nearest-even adder on a 24-bit significand plus guard/round/sticky bits.
    // Subnormals use exponent 1 with a hidden bit of 0, so they share the normal path.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
        logic        sb, a_nan, b_nan, a_inf, b_inf, swap, same, rnd;
        logic [31:0] x, y;
        logic [9:0]  ex, ey, e, e_out;
        logic [23:0] mx, my;
        logic [7:0]  d;
        logic [50:0] ext;
        logic [26:0] ax, ay, n;
        logic [27:0] s;
        logic [4:0]  lz, sh;
        logic [24:0] m_r;

        sb    = b[31] ^ sub;
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && (a[22:0] == 23'd0);
        b_inf = (&b[30:23]) && (b[22:0] == 23'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb))) return 32'h7FC0_0000;
        if (a_inf) return a;
        if (b_inf) return {sb, b[30:0]};

        swap = b[30:0] > a[30:0];
        x    = swap ? {sb, b[30:0]} : a;
        y    = swap ? a : {sb, b[30:0]};
        same = (x[31] == y[31]);
        ex   = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        ey   = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
        mx   = {x[30:23] != 8'd0, x[22:0]};
        my   = {y[30:23] != 8'd0, y[22:0]};
        d    = ex[7:0] - ey[7:0];

        ax  = {mx, 3'b000};
        ext = {my, 27'd0} >> d;
        if (d >= 8'd27) ay = {26'd0, |my};
        else            ay = {ext[50:25], |ext[24:0]};

        s = same ? ({1'b0, ax} + {1'b0, ay}) : ({1'b0, ax} - {1'b0, ay});
        if (s == 28'd0) return {same ? x[31] : 1'b0, 31'd0};

        e  = ex;
        lz = lzc27(s[26:0]);
        sh = lz;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            // Stop normalising at exponent 1; whatever is left over is a subnormal.
            if ({5'd0, lz} > e - 10'd1) sh = 5'(e - 10'd1);
            n = s[26:0] << sh;
            e = e - {5'd0, sh};
        end

        rnd = n[2] & (n[1] | n[0] | n[3]);
        m_r = {1'b0, n[26:3]} + {24'd0, rnd};
        if (m_r[24])      e_out = e + 10'd1;
        else if (m_r[23]) e_out = e;
        else              e_out = 10'd0;
        if (e_out >= 10'd255) return {x[31], 8'hFF, 23'd0};
        return {x[31], e_out[7:0], m_r[22:0]};
    endfunction
`endif

    // NOTE: every variable driven here gets a default first, so no path leaves a latch.
    always_comb begin
        result = 32'd0;
        wr_en  = 1'b0;
        case (op)
            OP_ADD: begin result = op_a + op_b; wr_en = 1'b1; end
            OP_SUB: begin result = op_a - op_b; wr_en = 1'b1; end
            OP_MUL: begin result = op_a * op_b; wr_en = 1'b1; end
            OP_DIV: begin
                wr_en = 1'b1;
                if (op_b == 32'd0)
                    result = 32'hFFFF_FFFF;
                else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF)
                    result = 32'h8000_0000;
                else
                    result = 32'($signed(op_a) / $signed(op_b));
            end
`ifdef FUNC_UNIT_FPU_EN
            OP_FADD: begin result = fp_add(op_a, op_b, 1'b0); wr_en = 1'b1; end
            OP_FSUB: begin result = fp_add(op_a, op_b, 1'b1); wr_en = 1'b1; end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the register file
    // is cleared on reset because lanes must start from a known all-zero image.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            final_result    <= 32'd0;
            thread_complete <= 1'b0;
        end else if (is_active) begin
            thread_complete <= (op == OP_DONE);
            if (op == OP_LOAD) begin
                regs <= init_reg_data;
            end else if (wr_en) begin
                regs[dest_reg] <= result;
                final_result   <= result;
            end
        end
    end

endmodule

// File: tb/tb_func_unit.sv
// Scoreboard bench for func_unit: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_func_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  type_instruction;
    logic [4:0]  regnum_1, regnum_2, dest_reg;
    logic [5:0]  shammt;
    logic [31:0] init_reg_data [0:31];
    logic        is_active;
    logic [31:0] final_result;
    logic        thread_complete;

    always #5 clk = ~clk;

    func_unit dut (
        .clk              (clk),
        .rst              (rst),
        .type_instruction (type_instruction),
        .regnum_1         (regnum_1),
        .regnum_2         (regnum_2),
        .dest_reg         (dest_reg),
        .shammt           (shammt),
        .init_reg_data    (init_reg_data),
        .is_active        (is_active),
        .final_result     (final_result),
        .thread_complete  (thread_complete)
    );

    typedef struct {
        logic [31:0] fr;
        logic        tc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_fr = 32'd0;
    logic        model_tc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected final_result only matters for ops that write; others hold the previous value.
    task automatic push_expect(input logic [2:0] op, input logic act, input logic [31:0] exp,
                               input string name);
        logic writes;
        writes = (op <= 3'd3);
`ifdef FUNC_UNIT_FPU_EN
        writes = writes || (op == 3'd4) || (op == 3'd5);
`endif
        if (act) begin
            if (writes) model_fr = exp;
            model_tc = (op == 3'd7);
        end
        sb_q.push_back('{model_fr, model_tc, name});
    endtask

    task automatic issue(input logic [2:0] op, input int ra, input int rb, input int rd,
                         input logic act, input logic [31:0] exp, input string name);
        @(negedge clk);
        rst              = 1'b0;
        type_instruction = op;
        regnum_1         = 5'(ra);
        regnum_2         = 5'(rb);
        dest_reg         = 5'(rd);
        is_active        = act;
        shammt           = 6'($urandom);
        push_expect(op, act, exp, name);
    endtask

    task automatic load_image(input int which, input string name);
        @(negedge clk);
        for (int i = 0; i < 32; i++) init_reg_data[i] = (which == 1) ? 32'(i) : 32'd0;
        if (which == 2) begin
            init_reg_data[1]  = 32'h3F80_0000;
            init_reg_data[2]  = 32'h4000_0000;
            init_reg_data[3]  = 32'h8000_0000;
            init_reg_data[4]  = 32'hFFFF_FFFF;
            init_reg_data[5]  = 32'h7FFF_FFFF;
            init_reg_data[6]  = 32'h0000_0001;
            init_reg_data[7]  = 32'h7F7F_FFFF;
            init_reg_data[8]  = 32'h7FC0_0001;
            init_reg_data[9]  = 32'h0000_0007;
            init_reg_data[10] = 32'hFFFF_FFF9;
            init_reg_data[11] = 32'h0000_0002;
            init_reg_data[12] = 32'h7F80_0000;
            init_reg_data[13] = 32'hFF80_0000;
            init_reg_data[14] = 32'h3380_0000;
            init_reg_data[15] = 32'h3F80_0001;
        end
        rst              = 1'b0;
        type_instruction = 3'b110;
        is_active        = 1'b1;
        shammt           = 6'($urandom);
        push_expect(3'b110, 1'b1, 32'd0, name);
    endtask

    // Monitor: one expectation per clock edge at which stimulus was applied.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.name, ".final_result"}, final_result, e.fr);
                check({e.name, ".thread_complete"}, {31'd0, thread_complete}, {31'd0, e.tc});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; type_instruction = 3'b111; is_active = 1'b1; shammt = 6'd0;
        regnum_1 = 5'd0; regnum_2 = 5'd0; dest_reg = 5'd0;
        for (int i = 0; i < 32; i++) init_reg_data[i] = 32'd0;
        repeat (2) @(posedge clk);

        // Reset beats a concurrent done opcode.
        @(negedge clk);
        rst = 1'b1; type_instruction = 3'b111; is_active = 1'b1;
        model_fr = 32'd0; model_tc = 1'b0;
        sb_q.push_back('{32'd0, 1'b0, "reset"});
        issue(3'b111, 0, 0, 0, 1'b1, 32'd0, "idle_done_a");
        issue(3'b111, 0, 0, 0, 1'b1, 32'd0, "idle_done_b");

        load_image(1, "load_ramp");
        issue(3'b000, 2, 4, 5, 1'b1, 32'd6, "add_r2_r4");
        issue(3'b001, 7, 6, 8, 1'b1, 32'd1, "sub_r7_r6");
        issue(3'b010, 10, 11, 12, 1'b1, 32'd110, "mul_r10_r11");
        issue(3'b011, 14, 15, 16, 1'b1, 32'd0, "div_r14_r15");
        issue(3'b000, 5, 8, 9, 1'b1, 32'd7, "add_r5_r8_readback");
        issue(3'b100, 18, 19, 20, 1'b1, 32'h0000_0025, "fadd_subnormal");
        issue(3'b101, 21, 22, 23, 1'b1, 32'h8000_0001, "fsub_subnormal_neg");
        issue(3'b000, 12, 16, 24, 1'b1, 32'd110, "add_r12_r16_readback");

        // Back-to-back dependency with shammt randomised on every issue.
        issue(3'b000, 1, 1, 1, 1'b1, 32'd2, "chain_1");
        issue(3'b000, 1, 1, 1, 1'b1, 32'd4, "chain_2");
        issue(3'b000, 1, 1, 1, 1'b1, 32'd8, "chain_3");
        issue(3'b001, 13, 1, 13, 1'b1, 32'd5, "sub_dest_is_src");

        // Lane gating.
        issue(3'b001, 5, 5, 5, 1'b1, 32'd0, "clear_r5");
        issue(3'b111, 0, 0, 0, 1'b0, 32'd0, "inactive_done");
        issue(3'b000, 2, 4, 5, 1'b0, 32'd0, "inactive_add");
        issue(3'b000, 5, 3, 25, 1'b1, 32'd3, "r5_still_zero");
        issue(3'b111, 0, 0, 0, 1'b1, 32'd0, "done_before_gate");
        issue(3'b000, 2, 4, 5, 1'b0, 32'd0, "inactive_holds_done");
        issue(3'b000, 2, 4, 5, 1'b1, 32'd6, "reactivated_add");
        issue(3'b000, 5, 0, 26, 1'b1, 32'd6, "r5_written");

        load_image(2, "load_edge");
        issue(3'b100, 1, 2, 16, 1'b1, 32'h4040_0000, "fadd_1_2");
        issue(3'b101, 1, 2, 17, 1'b1, 32'hBF80_0000, "fsub_1_2");
        issue(3'b011, 9, 0, 18, 1'b1, 32'hFFFF_FFFF, "div_by_zero");
        issue(3'b011, 3, 4, 19, 1'b1, 32'h8000_0000, "div_min_by_m1");
        issue(3'b011, 9, 4, 20, 1'b1, 32'hFFFF_FFF9, "div_7_by_m1");
        issue(3'b011, 10, 11, 21, 1'b1, 32'hFFFF_FFFD, "div_m7_by_2");
        issue(3'b000, 5, 6, 22, 1'b1, 32'h8000_0000, "add_overflow_wrap");
        issue(3'b100, 7, 7, 23, 1'b1, 32'h7F80_0000, "fadd_overflow_inf");
        issue(3'b100, 8, 1, 24, 1'b1, 32'h7FC0_0000, "fadd_nan");
        issue(3'b100, 12, 13, 25, 1'b1, 32'h7FC0_0000, "fadd_inf_minus_inf");
        issue(3'b101, 1, 1, 26, 1'b1, 32'h0000_0000, "fsub_exact_zero");
        issue(3'b100, 3, 3, 27, 1'b1, 32'h8000_0000, "fadd_negzero");
        issue(3'b100, 1, 14, 28, 1'b1, 32'h3F80_0000, "fadd_tie_even_down");
        issue(3'b100, 15, 14, 29, 1'b1, 32'h3F80_0002, "fadd_tie_even_up");
        issue(3'b010, 4, 4, 30, 1'b1, 32'h0000_0001, "mul_m1_m1");
        issue(3'b001, 0, 6, 31, 1'b1, 32'hFFFF_FFFF, "sub_underflow_wrap");
        issue(3'b111, 0, 0, 0, 1'b1, 32'd0, "done_final");
        issue(3'b000, 6, 6, 0, 1'b1, 32'd2, "write_r0");
        issue(3'b000, 0, 0, 1, 1'b1, 32'd4, "read_r0");

        @(negedge clk);
        is_active = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
